// File: rtl/errbit_pkg.sv
// ============================================================================
// Module   : errbit_pkg
// Brief    : Shared width helpers, default derived widths and stage tag type
//            for the frame-level error-bit accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package errbit_pkg;

    function automatic int clog2p1(input int value);
        return $clog2(value + 1);
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int N_DEFAULT             = 850;
    localparam int ROW_CHUNK_NUM_DEFAULT = 9;
    localparam int SEG_W_DEFAULT         = 128;

    localparam int FE_W  = clog2p1(N_DEFAULT * ROW_CHUNK_NUM_DEFAULT);
    localparam int SUM_W = clog2p1(N_DEFAULT);
    localparam int NSEG  = ceil_div(N_DEFAULT, SEG_W_DEFAULT);

    typedef struct packed {
        logic valid;
        logic last;
    } stage_tag_t;

endpackage

`default_nettype wire

// File: rtl/errbit_frame_accum_if.sv
// ============================================================================
// Module   : errbit_frame_accum_if
// Brief    : Hard-decision row-chunk stream into the error-bit accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface errbit_frame_accum_if #(
    parameter int N = 850
);
    logic         in_valid;
    logic         in_last;
    logic [N-1:0] in_data;

    modport master (
        output in_valid,
        output in_last,
        output in_data
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_data
    );
endinterface

`default_nettype wire

// File: rtl/errbit_popcnt_seg.sv
// ============================================================================
// Module   : errbit_popcnt_seg
// Brief    : Combinational population count over one SEG_W-bit segment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module errbit_popcnt_seg #(
    parameter int SEG_W = 128,
    parameter int CNT_W = 8
) (
    input  logic [SEG_W-1:0] seg_in,
    output logic [CNT_W-1:0] seg_cnt
);

    always_comb begin
        seg_cnt = '0;
        for (int i = 0; i < SEG_W; i++) begin
            seg_cnt = seg_cnt + CNT_W'(seg_in[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/errbit_frame_accum.sv
// ============================================================================
// Module   : errbit_frame_accum
// Brief    : Pipelined per-chunk popcount, per-frame error accumulation and
//            saturating BER/FER running totals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module errbit_frame_accum
    import errbit_pkg::*;
#(
    parameter int N             = 850,
    parameter int ROW_CHUNK_NUM = 9,
    parameter int SEG_W         = 128,
    parameter bit ZERO_IS_ERR   = 1'b1,
    parameter int TOT_W         = 32,
    parameter int SYN_LATENCY   = 2
) (
    input  logic                                    eval_clk,
    input  logic                                    rstn,
    errbit_frame_accum_if.slave                     in_if,
    input  logic                                    stats_clr,
    output logic                                    frame_valid,
    output logic [clog2p1(N*ROW_CHUNK_NUM)-1:0]     frame_err_cnt,
    output logic                                    frame_is_err,
    output logic                                    frame_done,
    output logic                                    busy,
    output logic [TOT_W-1:0]                        tot_err_bits,
    output logic [TOT_W-1:0]                        tot_err_frames,
    output logic [TOT_W-1:0]                        tot_frames,
    output logic                                    proto_err
);

    localparam int FRAME_W = clog2p1(N * ROW_CHUNK_NUM);
    localparam int CHUNK_W = clog2p1(N);
    localparam int SEG_NUM = ceil_div(N, SEG_W);
    localparam int SEGC_W  = clog2p1(SEG_W);
    localparam int CCNT_W  = clog2p1(ROW_CHUNK_NUM);
    localparam int DONE_W  = clog2p1(SYN_LATENCY);

    // ------------------------------------------------------------------
    // Pipeline registers S0..S3 and S4 frame/total state
    // ------------------------------------------------------------------
    stage_tag_t                        s0_tag_q,  s0_tag_d;
    logic [N-1:0]                      s0_data_q, s0_data_d;
    stage_tag_t                        s1_tag_q,  s1_tag_d;
    logic [SEG_NUM-1:0][SEGC_W-1:0]    s1_cnt_q,  s1_cnt_d;
    stage_tag_t                        s2_tag_q,  s2_tag_d;
    logic [CHUNK_W-1:0]                s2_sum_q,  s2_sum_d;
    stage_tag_t                        s3_tag_q,  s3_tag_d;
    logic [CHUNK_W-1:0]                s3_err_q,  s3_err_d;
    logic                              s4_valid_q, s4_valid_d;

    logic [FRAME_W-1:0]                acc_q, acc_d;
    logic                              frame_open_q, frame_open_d;
    logic [CCNT_W-1:0]                 chunk_cnt_q, chunk_cnt_d;
    logic [FRAME_W-1:0]                frame_err_cnt_q, frame_err_cnt_d;
    logic                              frame_is_err_q, frame_is_err_d;
    logic                              frame_valid_q, frame_valid_d;
    logic [DONE_W-1:0]                 done_cnt_q, done_cnt_d;
    logic                              proto_err_q, proto_err_d;
    logic [TOT_W-1:0]                  tot_err_bits_q, tot_err_bits_d;
    logic [TOT_W-1:0]                  tot_err_frames_q, tot_err_frames_d;
    logic [TOT_W-1:0]                  tot_frames_q, tot_frames_d;

    logic [SEG_NUM-1:0][SEGC_W-1:0]    seg_cnt;

    // ------------------------------------------------------------------
    // S1 segment popcounts; the short tail segment is zero-padded so that
    // padding never contributes ones regardless of ZERO_IS_ERR.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < SEG_NUM; g++) begin : g_seg
        localparam int LO  = g * SEG_W;
        localparam int REM = ((N - LO) < SEG_W) ? (N - LO) : SEG_W;
        logic [SEG_W-1:0] seg_bits;

        if (REM == SEG_W) begin : g_full
            assign seg_bits = s0_data_q[LO +: SEG_W];
        end else begin : g_pad
            assign seg_bits = {{(SEG_W-REM){1'b0}}, s0_data_q[LO +: REM]};
        end

        errbit_popcnt_seg #(
            .SEG_W (SEG_W),
            .CNT_W (SEGC_W)
        ) u_popcnt (
            .seg_in  (seg_bits),
            .seg_cnt (seg_cnt[g])
        );
    end

    always_comb begin
        s0_tag_d.valid = in_if.in_valid;
        s0_tag_d.last  = in_if.in_valid & in_if.in_last;
        s0_data_d      = in_if.in_data;

        s1_tag_d       = s0_tag_q;
        s1_cnt_d       = seg_cnt;

        s2_tag_d       = s1_tag_q;
        s2_sum_d       = '0;
        for (int i = 0; i < SEG_NUM; i++) begin
            s2_sum_d = s2_sum_d + CHUNK_W'(s1_cnt_q[i]);
        end

        s3_tag_d       = s2_tag_q;
        s3_err_d       = ZERO_IS_ERR ? (CHUNK_W'(N) - s2_sum_q) : s2_sum_q;

        s4_valid_d     = s3_tag_q.valid;
    end

    // ------------------------------------------------------------------
    // S4 frame accumulator, chunk counter, totals and frame_done stretch
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] acc_base;
    logic [FRAME_W:0]   acc_ext;
    logic [FRAME_W-1:0] acc_sum;
    logic [CCNT_W-1:0]  cnt_base;
    logic [CCNT_W-1:0]  cnt_next;
    logic [TOT_W:0]     bits_ext;

    always_comb begin
        acc_d            = acc_q;
        frame_open_d     = frame_open_q;
        chunk_cnt_d      = chunk_cnt_q;
        frame_err_cnt_d  = frame_err_cnt_q;
        frame_is_err_d   = frame_is_err_q;
        frame_valid_d    = 1'b0;
        proto_err_d      = proto_err_q;
        tot_err_bits_d   = tot_err_bits_q;
        tot_err_frames_d = tot_err_frames_q;
        tot_frames_d     = tot_frames_q;

        // A closed frame means the incoming chunk starts a fresh sum.
        acc_base = frame_open_q ? acc_q : '0;
        acc_ext  = {1'b0, acc_base} + (FRAME_W+1)'(s3_err_q);
        acc_sum  = acc_ext[FRAME_W] ? '1 : acc_ext[FRAME_W-1:0];
        cnt_base = frame_open_q ? chunk_cnt_q : '0;
        cnt_next = (&cnt_base) ? cnt_base : cnt_base + CCNT_W'(1);
        bits_ext = {1'b0, tot_err_bits_q} + (TOT_W+1)'(acc_sum);

        if (s3_tag_q.valid) begin
            if (s3_tag_q.last) begin
                acc_d           = acc_sum;
                frame_open_d    = 1'b0;
                chunk_cnt_d     = '0;
                frame_err_cnt_d = acc_sum;
                frame_is_err_d  = (acc_sum != '0);
                frame_valid_d   = 1'b1;
                tot_err_bits_d  = bits_ext[TOT_W] ? '1 : bits_ext[TOT_W-1:0];
                tot_frames_d    = (&tot_frames_q) ? tot_frames_q
                                                  : tot_frames_q + TOT_W'(1);
                if (acc_sum != '0 && !(&tot_err_frames_q)) begin
                    tot_err_frames_d = tot_err_frames_q + TOT_W'(1);
                end
            end else begin
                acc_d        = acc_sum;
                frame_open_d = 1'b1;
                chunk_cnt_d  = cnt_next;
                if (cnt_next >= CCNT_W'(ROW_CHUNK_NUM)) begin
                    proto_err_d = 1'b1;
                end
            end
        end

        if (stats_clr) begin
            tot_err_bits_d   = '0;
            tot_err_frames_d = '0;
            tot_frames_d     = '0;
            proto_err_d      = 1'b0;
        end

        if (frame_valid_d) begin
            done_cnt_d = DONE_W'(SYN_LATENCY);
        end else if (done_cnt_q != '0) begin
            done_cnt_d = done_cnt_q - DONE_W'(1);
        end else begin
            done_cnt_d = '0;
        end
    end

    always_ff @(posedge eval_clk or negedge rstn) begin
        if (!rstn) begin
            s0_tag_q         <= '0;
            s0_data_q        <= '0;
            s1_tag_q         <= '0;
            s1_cnt_q         <= '0;
            s2_tag_q         <= '0;
            s2_sum_q         <= '0;
            s3_tag_q         <= '0;
            s3_err_q         <= '0;
            s4_valid_q       <= 1'b0;
            acc_q            <= '0;
            frame_open_q     <= 1'b0;
            chunk_cnt_q      <= '0;
            frame_err_cnt_q  <= '0;
            frame_is_err_q   <= 1'b0;
            frame_valid_q    <= 1'b0;
            done_cnt_q       <= '0;
            proto_err_q      <= 1'b0;
            tot_err_bits_q   <= '0;
            tot_err_frames_q <= '0;
            tot_frames_q     <= '0;
        end else begin
            s0_tag_q         <= s0_tag_d;
            s0_data_q        <= s0_data_d;
            s1_tag_q         <= s1_tag_d;
            s1_cnt_q         <= s1_cnt_d;
            s2_tag_q         <= s2_tag_d;
            s2_sum_q         <= s2_sum_d;
            s3_tag_q         <= s3_tag_d;
            s3_err_q         <= s3_err_d;
            s4_valid_q       <= s4_valid_d;
            acc_q            <= acc_d;
            frame_open_q     <= frame_open_d;
            chunk_cnt_q      <= chunk_cnt_d;
            frame_err_cnt_q  <= frame_err_cnt_d;
            frame_is_err_q   <= frame_is_err_d;
            frame_valid_q    <= frame_valid_d;
            done_cnt_q       <= done_cnt_d;
            proto_err_q      <= proto_err_d;
            tot_err_bits_q   <= tot_err_bits_d;
            tot_err_frames_q <= tot_err_frames_d;
            tot_frames_q     <= tot_frames_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_err_cnt  = frame_err_cnt_q;
    assign frame_is_err   = frame_is_err_q;
    assign frame_done     = (done_cnt_q != '0);
    assign proto_err      = proto_err_q;
    assign tot_err_bits   = tot_err_bits_q;
    assign tot_err_frames = tot_err_frames_q;
    assign tot_frames     = tot_frames_q;
    assign busy           = frame_open_q | s0_tag_q.valid | s1_tag_q.valid |
                            s2_tag_q.valid | s3_tag_q.valid | s4_valid_q;

endmodule

`default_nettype wire
